// File: rtl/zip_pkg.sv
// Shared types and defaults for the IQ compressor front end.
// Holds the arbiter state encoding and datapath geometry.
package zip_pkg;

    localparam int ZIP_WIDTH = 32;
    localparam int ZIP_GROUP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        PAD  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// Remembers the last served requester; tie goes to the other one.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_chan,
    output logic       gnt,
    output logic       gnt_valid
);

    logic last_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (upd) begin
            last_gnt <= upd_chan;
        end
    end

    always_comb begin
        gnt       = 1'b0;
        gnt_valid = |req;
        unique case (req)
            2'b11:   gnt = ~last_gnt;
            2'b10:   gnt = 1'b1;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/zip_pkt_arbiter.sv
// Packet round-robin arbiter feeding the 4:1 IQ compressor.
// Pads short packet tails with zero beats up to a GROUP boundary.
module zip_pkt_arbiter
    import zip_pkg::*;
#(
    parameter int WIDTH = ZIP_WIDTH,
    parameter int GROUP = ZIP_GROUP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s0_tdata,
    input  logic             s0_tlast,
    input  logic             s0_tvalid,
    output logic             s0_tready,
    input  logic [WIDTH-1:0] s1_tdata,
    input  logic             s1_tlast,
    input  logic             s1_tvalid,
    output logic             s1_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             o_chan,
    output logic             o_pad_pulse
);

    localparam int CW = $clog2(GROUP);
    localparam logic [CW-1:0] LAST = CW'(GROUP - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t          state, state_n;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   pad_rem;
    logic            gnt, gnt_valid;
    logic            acc, done;
    logic            sel_valid, sel_last;
    logic [WIDTH-1:0] sel_data;

    assign sel_valid = o_chan ? s1_tvalid : s0_tvalid;
    assign sel_last  = o_chan ? s1_tlast  : s0_tlast;
    assign sel_data  = o_chan ? s1_tdata  : s0_tdata;
    assign acc       = o_tvalid & o_tready;

    // Packet fully forwarded: either aligned tlast or final pad beat.
    assign done = (state == PASS && acc && sel_last && beat_cnt == LAST)
               || (state == PAD && acc && pad_rem == ONE);

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({s1_tvalid, s0_tvalid}),
        .upd       (done),
        .upd_chan  (o_chan),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt    <= '0;
            pad_rem     <= '0;
            o_chan      <= 1'b0;
            o_pad_pulse <= 1'b0;
        end else begin
            o_pad_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        o_chan <= gnt;
                    end
                end
                PASS: begin
                    if (acc) begin
                        beat_cnt <= beat_cnt + ONE;
                        if (sel_last && beat_cnt != LAST) begin
                            pad_rem     <= LAST - beat_cnt;
                            o_pad_pulse <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (acc) begin
                        pad_rem <= pad_rem - ONE;
                        if (pad_rem == ONE) begin
                            beat_cnt <= '0;
                        end
                    end
                end
                default: begin
                    beat_cnt <= '0;
                    pad_rem  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    state_n = PASS;
                end
            end
            PASS: begin
                if (acc && sel_last) begin
                    state_n = (beat_cnt == LAST) ? IDLE : PAD;
                end
            end
            PAD: begin
                if (acc && pad_rem == ONE) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        o_tdata   = '0;
        o_tvalid  = 1'b0;
        o_tlast   = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        unique case (state)
            PASS: begin
                o_tvalid  = sel_valid;
                o_tdata   = sel_valid ? sel_data : '0;
                o_tlast   = sel_valid && sel_last && beat_cnt == LAST;
                s0_tready = !o_chan && o_tready;
                s1_tready = o_chan && o_tready;
            end
            PAD: begin
                o_tvalid = 1'b1;
                o_tlast  = (pad_rem == ONE);
            end
            default: begin
                o_tvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_zip_pkt_arbiter.sv
// Directed bench for zip_pkt_arbiter: packets, padding,
// round-robin alternation, backpressure and mid-packet reset.
module tb_zip_pkt_arbiter;

    localparam int GROUP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s0_tdata, s1_tdata, o_tdata;
    logic        s0_tlast, s1_tlast, o_tlast;
    logic        s0_tvalid, s1_tvalid, o_tvalid;
    logic        s0_tready, s1_tready, o_tready;
    logic        o_chan, o_pad_pulse;

    int errors = 0;
    int checks = 0;

    zip_pkt_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .s0_tdata    (s0_tdata),
        .s0_tlast    (s0_tlast),
        .s0_tvalid   (s0_tvalid),
        .s0_tready   (s0_tready),
        .s1_tdata    (s1_tdata),
        .s1_tlast    (s1_tlast),
        .s1_tvalid   (s1_tvalid),
        .s1_tready   (s1_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .o_chan      (o_chan),
        .o_pad_pulse (o_pad_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        s0_tdata  = '0; s0_tlast = 0; s0_tvalid = 0;
        s1_tdata  = '0; s1_tlast = 0; s1_tvalid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        o_tready = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, {31'd0, o_tvalid}, 0);
        chk({tag, "_tlast"}, {31'd0, o_tlast}, 0);
        chk({tag, "_tdata"}, o_tdata, 0);
        chk({tag, "_chan"}, {31'd0, o_chan}, 0);
        chk({tag, "_s0rdy"}, {31'd0, s0_tready}, 0);
        chk({tag, "_s1rdy"}, {31'd0, s1_tready}, 0);
        chk({tag, "_pulse"}, {31'd0, o_pad_pulse}, 0);
    endtask

    // Send one packet of n beats on stream ch and check everything forwarded.
    task automatic run_pkt(input bit ch, input int n,
                           input logic [31:0] base, input bit bp,
                           input string tag);
        logic [31:0] dq[$];
        bit          lq[$];
        int          idx = 0, pulses = 0, ncyc = 0, p;
        bit          done = 0, stall = 0, pl = 0;
        logic [31:0] pd = '0;
        p = (GROUP - n % GROUP) % GROUP;
        while (!done && ncyc < 200) begin
            idle_inputs();
            if (idx < n) begin
                if (ch) begin
                    s1_tvalid = 1; s1_tdata = base + idx; s1_tlast = (idx == n - 1);
                end else begin
                    s0_tvalid = 1; s0_tdata = base + idx; s0_tlast = (idx == n - 1);
                end
            end
            o_tready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            #4;
            if (o_pad_pulse) pulses++;
            if (stall) begin
                chk({tag, "_stall_valid"}, {31'd0, o_tvalid}, 1);
                chk({tag, "_stall_data"}, o_tdata, pd);
                chk({tag, "_stall_last"}, {31'd0, o_tlast}, {31'd0, pl});
            end
            if (o_tvalid) chk({tag, "_chan"}, {31'd0, o_chan}, {31'd0, ch});
            else chk({tag, "_idle_data"}, o_tdata, 0);
            stall = o_tvalid && !o_tready;
            pd = o_tdata;
            pl = o_tlast;
            if (o_tvalid && o_tready) begin
                dq.push_back(o_tdata);
                lq.push_back(o_tlast);
                if (o_tlast) done = 1;
            end
            if (idx < n && (ch ? s1_tready : s0_tready)) idx++;
            @(posedge clk);
            #1;
            ncyc++;
        end
        idle_inputs();
        chk({tag, "_timeout"}, {31'd0, done}, 1);
        chk({tag, "_nbeats"}, dq.size(), n + p);
        for (int i = 0; i < dq.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), dq[i],
                (i < n) ? base + i : 32'd0);
            chk($sformatf("%s_last%0d", tag, i), {31'd0, lq[i]},
                (i == n + p - 1) ? 32'd1 : 32'd0);
        end
        chk({tag, "_pulses"}, pulses, (p != 0) ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    // Both streams hold two 4-beat packets each, continuously valid.
    task automatic run_dual();
        int i0 = 0, i1 = 0, beats = 0, idle = 0, ncyc = 0;
        int pkt, sidx;
        bit ch;
        while (beats < 16 && ncyc < 100) begin
            idle_inputs();
            o_tready = 1;
            if (i0 < 8) begin
                s0_tvalid = 1; s0_tdata = 32'hA000_0000 + i0; s0_tlast = (i0 % 4 == 3);
            end
            if (i1 < 8) begin
                s1_tvalid = 1; s1_tdata = 32'hB000_0000 + i1; s1_tlast = (i1 % 4 == 3);
            end
            #4;
            if (o_tvalid) begin
                pkt  = beats / 4;
                ch   = pkt[0];
                sidx = (pkt / 2) * 4 + beats % 4;
                chk($sformatf("rr_chan%0d", beats), {31'd0, o_chan}, {31'd0, ch});
                chk($sformatf("rr_data%0d", beats), o_tdata,
                    (ch ? 32'hB000_0000 : 32'hA000_0000) + sidx);
                chk($sformatf("rr_last%0d", beats), {31'd0, o_tlast},
                    (beats % 4 == 3) ? 32'd1 : 32'd0);
                if (beats % 4 == 0 && beats > 0)
                    chk($sformatf("rr_gap%0d", pkt), idle, 1);
                if (o_tlast) idle = 0;
                beats++;
            end else begin
                idle++;
            end
            if (i0 < 8 && s0_tready) i0++;
            if (i1 < 8 && s1_tready) i1++;
            @(posedge clk);
            #1;
            ncyc++;
        end
        idle_inputs();
        chk("rr_timeout", beats, 16);
    endtask

    initial begin
        do_reset();
        #4;
        chk_reset_outputs("rst");
        @(posedge clk);
        #1;

        run_pkt(0, 8, 32'h1000_0000, 0, "p8");
        run_pkt(0, 5, 32'h2000_0000, 0, "p5");

        do_reset();
        run_dual();

        run_pkt(1, 5, 32'h3000_0000, 1, "bp5");
        run_pkt(0, 6, 32'h4000_0000, 1, "bp6");
        run_pkt(0, 8, 32'h5000_0000, 1, "bp8");

        run_pkt(1, 1, 32'h1234_5678, 0, "one");
        run_pkt(1, 3, 32'h6000_0000, 0, "alone");

        // Abandon a packet two beats in with reset.
        s0_tvalid = 1; s0_tdata = 32'h7000_0000; s0_tlast = 0; o_tready = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        reset = 0;
        idle_inputs();
        run_pkt(0, 4, 32'h8000_0000, 0, "post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
